pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Instruction-fetch sequencer and PC register. It drives `pc` into the existing `pc_increment` adder and consumes the returned `pc4`. It runs a req/ack handshake with instruction memory and presents one buffered instruction, with its PC+4, to the ID stage under a valid/ready handshake. It takes branch/jump redirects from ID and squashes any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high; highest priority.
- pc  out  32  address of the current or next fetch; feeds `pc_increment`. `pc_increment`'s clrn is tied high at the top level.
- pc4  in  32  pc + 4 returned from `pc_increment` (combinational).
- redirect  in  1  ID requests a PC change this cycle.
- redirect_pc  in  32  target address for the redirect.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals `pc`.
- imem_ack  in  1  memory returns data; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst  out  32  buffered instruction to ID.
- inst_pc4  out  32  PC+4 of the buffered instruction.
- inst_valid  out  1  buffer holds a live instruction.
- id_ready  in  1  ID consumes `inst` at the edge where inst_valid & id_ready.

Behaviour:
- Reset (clr=1 at an edge), regardless of state:
  - state<=BOOT; pc<=RESET_PC; pend_pc<=0.
  - inst<=0; inst_pc4<=0; inst_valid<=0.
  - imem_req is 0 in BOOT.
- States: BOOT, FETCH, HOLD, DRAIN.
- imem_req = (FETCH) | (DRAIN) | (HOLD & id_ready). imem_addr = pc.
- Once raised, req stays high with imem_addr stable until an ack edge. An ack may arrive in the same cycle req rises (zero-wait memory).
- BOOT: go to FETCH the next edge. First request appears exactly 1 cycle after clr deasserts.
- FETCH, no redirect:
  - ack: inst<=imem_rdata; inst_pc4<=pc4; inst_valid<=1; pc<=pc4; go to HOLD.
  - no ack: hold all state.
- HOLD (inst_valid=1):
  - id_ready & ack: capture the new instruction as in FETCH; stay in HOLD.
  - id_ready & no ack: inst_valid<=0; go to FETCH.
  - id_ready=0: hold everything; req is low.
- Redirect (ignored only when clr=1). It always clears inst_valid at the edge; the buffered instruction is wrong-path. Per state:
  - FETCH with ack: discard the data; pc<=redirect_pc; stay in FETCH.
  - FETCH without ack: pend_pc<=redirect_pc; go to DRAIN. pc is unchanged so the outstanding address stays stable.
  - HOLD: pc<=redirect_pc; go to FETCH. Any same-cycle ack data is discarded.
  - BOOT: pc<=redirect_pc; go to FETCH.
- DRAIN:
  - Wait for ack, then discard the data; pc<=pend_pc; go to FETCH.
  - A further redirect in DRAIN overwrites pend_pc (latest wins). If it coincides with the ack, pc<=redirect_pc.
  - inst_valid stays 0 throughout.
- Throughput: with zero-wait memory and id_ready=1, one instruction per cycle after the first. Fetch latency from req to inst_valid is ack latency + 1 edge.
- Arithmetic: the block does no addition; all increments come from `pc4`. Wrap 0xFFFF_FFFC -> 0x0000_0000 follows the adder's modulo-2^32 result.
- imem_rdata is never registered without ack. An ack while req=0 is ignored.

Decomposition:
- Shared include `fetch_defs.vh` holds:
  - 2-bit state encodings FS_BOOT=0, FS_FETCH=1, FS_HOLD=2, FS_DRAIN=3;
  - the RESET_PC default.
- No new sub-module. The `pc_increment` instance lives in the IF-stage top, beside this block, wired pc -> pc4.

Test Plan:
1. clr=1 for 2 cycles, then 0: during reset pc=0, req=0, inst_valid=0. The cycle after release is BOOT (req=0); the next cycle gives req=1, addr=0.
2. Zero-wait memory (ack=req, rdata=addr^0xA5A5A5A5), id_ready=1: imem_addr 0,4,8,12 on consecutive cycles; inst_pc4 4,8,12; inst_valid high continuously after the first capture.
3. Backpressure: id_ready=0 for 3 cycles after the first capture. inst stays at the addr-0 data and req=0. id_ready rises -> req=1, addr=4 that cycle; inst updates at the next edge.
4. Ack latency 3, redirect to 0x100 one cycle after req rises: imem_addr holds its previous value until ack. Returned data is discarded with inst_valid=0. The next request has addr 0x100, then inst_pc4=0x104.
5. Redirect to 0x200 on the same edge as ack in FETCH: data discarded, inst_valid=0. Next request addr 0x200 with no DRAIN visit.
6. clr asserted during DRAIN (pend_pc=0x300): next cycle state BOOT, pc=RESET_PC, inst_valid=0. The first post-reset request is addr 0, not 0x300.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings
// and the default reset fetch address.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory req/ack, ID valid/ready buffer and the
// branch/jump redirect coming back from ID.
interface pc_fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc4;
  logic        inst_valid;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst, inst_pc4, inst_valid,
    input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc4, inst_valid,
    output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer and PC register. Increments come from the
// external pc_increment adder via pc4; this block performs no addition.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            clr,
  output logic [31:0]     pc,
  input  logic [31:0]     pc4,
  pc_fetch_ctrl_if.master fif
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_n, pend_pc, pend_pc_n;
  logic [31:0]  inst_r, inst_n, inst_pc4_r, inst_pc4_n;
  logic         valid_r, valid_n;
  logic         req, ack;

  // An ack is only meaningful while a request is outstanding.
  assign req = (state == FS_FETCH) || (state == FS_DRAIN) ||
               ((state == FS_HOLD) && fif.id_ready);
  assign ack = req && fif.imem_ack;

  assign fif.imem_req   = req;
  assign fif.imem_addr  = pc;
  assign fif.inst       = inst_r;
  assign fif.inst_pc4   = inst_pc4_r;
  assign fif.inst_valid = valid_r;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_pc_n  = pend_pc;
    inst_n     = inst_r;
    inst_pc4_n = inst_pc4_r;
    valid_n    = valid_r;

    case (state)
      FS_BOOT: begin
        state_n = FS_FETCH;
        if (fif.redirect) pc_n = fif.redirect_pc;
      end

      FS_FETCH: begin
        if (fif.redirect) begin
          // Without an ack the address must stay stable, so park the target.
          if (ack) begin
            pc_n = fif.redirect_pc;
          end else begin
            pend_pc_n = fif.redirect_pc;
            state_n   = FS_DRAIN;
          end
        end else if (ack) begin
          inst_n     = fif.imem_rdata;
          inst_pc4_n = pc4;
          valid_n    = 1'b1;
          pc_n       = pc4;
          state_n    = FS_HOLD;
        end
      end

      FS_HOLD: begin
        if (fif.redirect) begin
          pc_n    = fif.redirect_pc;
          state_n = FS_FETCH;
        end else if (fif.id_ready) begin
          if (ack) begin
            inst_n     = fif.imem_rdata;
            inst_pc4_n = pc4;
            pc_n       = pc4;
          end else begin
            valid_n = 1'b0;
            state_n = FS_FETCH;
          end
        end
      end

      FS_DRAIN: begin
        if (fif.redirect) begin
          if (ack) begin
            pc_n    = fif.redirect_pc;
            state_n = FS_FETCH;
          end else begin
            pend_pc_n = fif.redirect_pc;
          end
        end else if (ack) begin
          pc_n    = pend_pc;
          state_n = FS_FETCH;
        end
      end

      default: state_n = FS_BOOT;
    endcase

    // The buffered instruction is always wrong-path once ID redirects.
    if (fif.redirect) valid_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= FS_BOOT;
      pc         <= RESET_PC;
      pend_pc    <= 32'h0;
      inst_r     <= 32'h0;
      inst_pc4_r <= 32'h0;
      valid_r    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_pc    <= pend_pc_n;
      inst_r     <= inst_n;
      inst_pc4_r <= inst_pc4_n;
      valid_r    <= valid_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table followed by
// hand-written redirect/drain and address-wrap sequences.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc, pc4;

  pc_fetch_ctrl_if fif ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .clr (clr),
    .pc  (pc),
    .pc4 (pc4),
    .fif (fif)
  );

  // Stand-in for pc_increment and a memory whose word is addr ^ pattern.
  assign pc4            = pc + 32'd4;
  assign fif.imem_rdata = fif.imem_addr ^ 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        idr;
    logic        ack;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic drive(input logic c, input logic idr, input logic ack,
                       input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    clr             = c;
    fif.id_ready    = idr;
    fif.imem_ack    = ack;
    fif.redirect    = rd;
    fif.redirect_pc = rpc;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    clr = 1'b1; fif.id_ready = 1'b0; fif.imem_ack = 1'b0;
    fif.redirect = 1'b0; fif.redirect_pc = 32'h0;
    @(posedge clk);

    //              clr idr ack rd  rpc           req addr        vld inst          pc4
    tv.push_back('{1'b1,1'b0,1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,32'h0,        32'h0});   // 0 reset
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,32'h0,        32'h0});   // 1 BOOT
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h0,     1'b0,32'h0,        32'h0});   // 2 first req
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h4,     1'b1,32'hA5A5A5A5,32'h4});   // 3
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h8,     1'b1,32'hA5A5A5A1,32'h8});   // 4
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'hC,     1'b1,32'hA5A5A5AD,32'hC});   // 5
    tv.push_back('{1'b0,1'b0,1'b1,1'b0,32'h0,     1'b0,32'h10,    1'b1,32'hA5A5A5A9,32'h10});  // 6 stall, stray ack
    tv.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,     1'b0,32'h10,    1'b1,32'hA5A5A5A9,32'h10});  // 7
    tv.push_back('{1'b0,1'b0,1'b1,1'b0,32'h0,     1'b0,32'h10,    1'b1,32'hA5A5A5A9,32'h10});  // 8
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b1,32'h10,    1'b1,32'hA5A5A5A9,32'h10});  // 9 ready, no ack
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h10,    1'b0,32'hA5A5A5A9,32'h10});  // 10
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b1,32'h14,    1'b1,32'hA5A5A5B5,32'h14});  // 11
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b1,32'h14,    1'b0,32'hA5A5A5B5,32'h14});  // 12 slow mem
    tv.push_back('{1'b0,1'b1,1'b0,1'b1,32'h100,   1'b1,32'h14,    1'b0,32'hA5A5A5B5,32'h14});  // 13 redirect -> DRAIN
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b1,32'h14,    1'b0,32'hA5A5A5B5,32'h14});  // 14
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h14,    1'b0,32'hA5A5A5B5,32'h14});  // 15 late ack dropped
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h100,   1'b0,32'hA5A5A5B5,32'h14});  // 16
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b1,32'h104,   1'b1,32'hA5A5A4A5,32'h104}); // 17
    tv.push_back('{1'b0,1'b1,1'b1,1'b1,32'h200,   1'b1,32'h104,   1'b0,32'hA5A5A4A5,32'h104}); // 18 redirect + ack
    tv.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,     1'b1,32'h200,   1'b0,32'hA5A5A4A5,32'h104}); // 19 no DRAIN
    tv.push_back('{1'b0,1'b1,1'b1,1'b1,32'h280,   1'b1,32'h204,   1'b1,32'hA5A5A7A5,32'h204}); // 20 redirect in HOLD
    tv.push_back('{1'b0,1'b1,1'b0,1'b1,32'h300,   1'b1,32'h280,   1'b0,32'hA5A5A7A5,32'h204}); // 21 -> DRAIN 0x300
    tv.push_back('{1'b1,1'b1,1'b1,1'b1,32'h400,   1'b1,32'h280,   1'b0,32'hA5A5A7A5,32'h204}); // 22 clr in DRAIN
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,32'h0,        32'h0});   // 23 BOOT
    tv.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,     1'b1,32'h0,     1'b0,32'h0,        32'h0});   // 24 addr 0

    foreach (tv[i]) begin
      drive(tv[i].clr, tv[i].idr, tv[i].ack, tv[i].redir, tv[i].rpc);
      nvec++;
      if ({fif.imem_req, fif.imem_addr, fif.inst_valid, fif.inst, fif.inst_pc4} !==
          {tv[i].e_req, tv[i].e_addr, tv[i].e_valid, tv[i].e_inst, tv[i].e_pc4}) begin
        nmis++;
        $display("FAIL vec%0d: got req=%b addr=%h vld=%b inst=%h pc4=%h, expected req=%b addr=%h vld=%b inst=%h pc4=%h",
                 i, fif.imem_req, fif.imem_addr, fif.inst_valid, fif.inst, fif.inst_pc4,
                 tv[i].e_req, tv[i].e_addr, tv[i].e_valid, tv[i].e_inst, tv[i].e_pc4);
      end
    end

    // Repeated redirects while draining: the latest target wins, and one
    // coinciding with the ack is taken directly.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
    chk("drain_enter_addr", fif.imem_addr, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h600);
    chk("drain_req", {31'h0, fif.imem_req}, 32'h1);
    chk("drain_addr_stable", fif.imem_addr, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_valid", {31'h0, fif.inst_valid}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h700);
    chk("latest_wins_addr", fif.imem_addr, 32'h600);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h800);
    chk("drain2_addr", fif.imem_addr, 32'h600);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_ack_addr", fif.imem_addr, 32'h800);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("after_drain_valid", {31'h0, fif.inst_valid}, 32'h1);
    chk("after_drain_inst", fif.inst, 32'hA5A5ADA5);
    chk("after_drain_pc4", fif.inst_pc4, 32'h804);

    // Redirect during BOOT to the top word; the adder wraps PC to zero.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("boot_req", {31'h0, fif.imem_req}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", fif.imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_next_addr", fif.imem_addr, 32'h0);
    chk("wrap_pc4", fif.inst_pc4, 32'h0);
    chk("wrap_inst", fif.inst, 32'h5A5A5A59);
    chk("wrap_stall_req", {31'h0, fif.imem_req}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
